exec_unit: RTL

EXEC_UNIT -- requirements
Module: exec_unit

---
 rtl/exec_pkg.sv | 29 ++
 rtl/exec_unit_if.sv | 37 +++
 rtl/exec_unit_mul_seq.sv | 44 ++++
 rtl/exec_unit.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/exec_pkg.sv
// Shared types and constants for the exec_unit slice.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package exec_pkg;

  // Default datapath width, matching the register file bus
  localparam int WIDTH_DEF = 16;

  // Opcodes as carried on the op field
  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_SHL = 3'b101,
    OP_SHR = 3'b110,
    OP_MUL = 3'b111
  } op_e;

  // Control FSM states
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_MUL  = 2'd2,
    S_WB   = 2'd3
  } state_e;

endpackage

// File: rtl/exec_unit_if.sv
// Request/writeback bundle between a sequencer and exec_unit.
// Latency: wires only.
// Backpressure: requester must hold off start while busy=1; extra starts are dropped.
interface exec_unit_if
  import exec_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
);
  // request side
  logic             start;
  logic [2:0]       op;
  logic [2:0]       dst;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  // status / writeback side
  logic             busy;
  logic             done;
  logic             we;
  logic [2:0]       c_index;
  logic [WIDTH-1:0] d_output;
  logic             zero;
  logic             carry;
  logic             err;

  // The sequencer / bench side
  modport master (
    output start, op, dst, a_in, b_in,
    input  busy, done, we, c_index, d_output, zero, carry, err
  );

  // The execution unit side
  modport slave (
    input  start, op, dst, a_in, b_in,
    output busy, done, we, c_index, d_output, zero, carry, err
  );

endinterface

// File: rtl/exec_unit_mul_seq.sv
// Shift-add multiplier: low WIDTH bits of a*b, one partial product per step.
// Latency: load cycle plus WIDTH step cycles; product valid after the last step.
// Backpressure: none; the parent sequences load/step and must not overlap uses.
module mul_seq
  import exec_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             step,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] product
);

  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] acc;

  // Load operands, then add the shifted multiplicand whenever the current
  // multiplier LSB is set; bits shifted past WIDTH are simply discarded.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
    end else if (load) begin
      mcand  <= a;
      mplier <= b;
      acc    <= '0;
    end else if (step) begin
      if (mplier[0]) begin
        acc <= acc + mcand;
      end
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
    end
  end

  assign product = acc;

endmodule

// File: rtl/exec_unit.sv
// Single-issue execution unit: ALU ops plus optional iterative MUL, writeback to regfile.
// Latency: accept-to-WB 2 cycles (ALU), WIDTH+2 cycles (MUL, only with EXEC_UNIT_MUL_EN).
// Backpressure: busy=1 from accept through WB; start is ignored while busy, no queuing.
module exec_unit
  import exec_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  exec_unit_if.slave   bus
);

  state_e           state;
  state_e           state_n;

  // operands and destination captured at accept
  op_e              op_q;
  logic [2:0]       dst_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;

  // result staged between EXEC and WB
  logic [WIDTH-1:0] res_q;
  logic             cy_q;
  logic             er_q;

  // status of the last completed operation
  logic             zero_q;
  logic             carry_q;
  logic             err_q;

  // combinational ALU outputs
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] alu_res;
  logic             alu_cy;
  logic             alu_err;

  // value presented during WB
  logic [WIDTH-1:0] wb_res;

  op_e              op_in;
  logic             accept;

  assign op_in  = op_e'(bus.op);
  assign accept = (state == S_IDLE) && bus.start;

`ifdef EXEC_UNIT_MUL_EN
  localparam int CW = $clog2(WIDTH + 1);

  logic [CW-1:0]    cnt;
  logic             mul_load;
  logic             mul_step;
  logic [WIDTH-1:0] product;

  mul_seq #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (mul_load),
    .step    (mul_step),
    .a       (a_q),
    .b       (b_q),
    .product (product)
  );

  // MUL cycle counter: slot 0 loads the multiplier, slots 1..WIDTH step it
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (state == S_MUL) begin
      cnt <= cnt + 1'b1;
    end else begin
      cnt <= '0;
    end
  end

  // Multiplier drive derived from the counter slot
  always_comb begin
    mul_load = 1'b0;
    mul_step = 1'b0;
    if (state == S_MUL) begin
      if (cnt == '0) begin
        mul_load = 1'b1;
      end else begin
        mul_step = 1'b1;
      end
    end
  end

  // MUL results come straight from the multiplier accumulator
  assign wb_res = (op_q == OP_MUL) ? product : res_q;
`else
  assign wb_res = res_q;
`endif

  // ALU: one-cycle evaluation of the latched operands
  always_comb begin
    sum     = {1'b0, a_q} + {1'b0, b_q};
    diff    = {1'b0, a_q} - {1'b0, b_q};
    alu_res = '0;
    alu_cy  = 1'b0;
    alu_err = 1'b0;
    case (op_q)
      OP_ADD: begin
        alu_res = sum[WIDTH-1:0];
        alu_cy  = sum[WIDTH];
      end
      OP_SUB: begin
        // the extra MSB of the widened difference is the unsigned borrow
        alu_res = diff[WIDTH-1:0];
        alu_cy  = diff[WIDTH];
      end
      OP_AND: alu_res = a_q & b_q;
      OP_OR:  alu_res = a_q | b_q;
      OP_XOR: alu_res = a_q ^ b_q;
      OP_SHL: alu_res = a_q << b_q[3:0];
      OP_SHR: alu_res = a_q >> b_q[3:0];
      OP_MUL: begin
`ifndef EXEC_UNIT_MUL_EN
        // no multiplier built: report the op as unsupported, result stays 0
        alu_err = 1'b1;
`endif
      end
      default: alu_res = '0;
    endcase
  end

  // FSM next state and all bus outputs; outputs are quiet outside WB
  always_comb begin
    state_n      = state;
    bus.busy     = 1'b0;
    bus.done     = 1'b0;
    bus.we       = 1'b0;
    bus.c_index  = '0;
    bus.d_output = '0;
    bus.zero     = zero_q;
    bus.carry    = carry_q;
    bus.err      = err_q;
    case (state)
      S_IDLE: begin
        if (bus.start) begin
`ifdef EXEC_UNIT_MUL_EN
          state_n = (op_in == OP_MUL) ? S_MUL : S_EXEC;
`else
          state_n = S_EXEC;
`endif
        end
      end
      S_EXEC: begin
        bus.busy = 1'b1;
        state_n  = S_WB;
      end
      S_MUL: begin
        bus.busy = 1'b1;
`ifdef EXEC_UNIT_MUL_EN
        if (cnt == CW'(WIDTH)) begin
          state_n = S_WB;
        end
`else
        state_n = S_IDLE;
`endif
      end
      S_WB: begin
        // new status is shown during WB and then held by the *_q registers
        bus.busy     = 1'b1;
        bus.done     = 1'b1;
        bus.we       = ~er_q;
        bus.c_index  = dst_q;
        bus.d_output = wb_res;
        bus.zero     = (wb_res == '0);
        bus.carry    = cy_q;
        bus.err      = er_q;
        state_n      = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // State register, operand latch, result staging and status hold
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      op_q    <= OP_ADD;
      dst_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      cy_q    <= 1'b0;
      er_q    <= 1'b0;
      zero_q  <= 1'b0;
      carry_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state <= state_n;
      if (accept) begin
        op_q  <= op_in;
        dst_q <= bus.dst;
        a_q   <= bus.a_in;
        b_q   <= bus.b_in;
        // MUL never passes through EXEC, so clear staged flags here
        res_q <= '0;
        cy_q  <= 1'b0;
        er_q  <= 1'b0;
      end
      if (state == S_EXEC) begin
        res_q <= alu_res;
        cy_q  <= alu_cy;
        er_q  <= alu_err;
      end
      if (state == S_WB) begin
        zero_q  <= (wb_res == '0);
        carry_q <= cy_q;
        err_q   <= er_q;
      end
    end
  end

endmodule
